// File: rtl/rotfpga_scan_loader_if.sv
// Stream-side handshake bundle for the rotatable-tile FPGA scan loader.
//   din/din_valid/din_ready    : load data stream into the controller
//   dout/dout_valid/dout_ready : readback data stream out of the controller
// Modports:
//   slave  - the scan loader (consumes din, produces dout)
//   master - the IO mux / host side (produces din, consumes dout)
interface rotfpga_scan_loader_if #(
  parameter int unsigned CHAINS = 2
);
  logic [CHAINS-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [CHAINS-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );
endinterface

// File: rtl/rotfpga_scan_loader.sv
// Configuration controller for the rotatable-tile FPGA grid. Drives CHAINS
// parallel scan chains of CHAIN_LEN bits: streamed load with backpressure,
// non-destructive recirculating readback, per-chain parity and abort.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start, mode        - begin op in IDLE (00 load, 01 readback, others error)
//   abort              - terminate a running load/readback
//   strm (slave)       - din/din_valid/din_ready, dout/dout_valid/dout_ready
//   sc_en, sc_out      - grid scan enable and scan inputs
//   sc_in              - grid scan outputs (tail of each chain)
//   parity             - XOR of all bits shifted into each chain last op
//   busy, done, err    - not idle, one-cycle completion pulse, sticky error
module rotfpga_scan_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CHAINS    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 abort,
  rotfpga_scan_loader_if.slave strm,
  output logic                 sc_en,
  output logic [CHAINS-1:0]    sc_out,
  input  logic [CHAINS-1:0]    sc_in,
  output logic [CHAINS-1:0]    parity,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] counter;
  logic          last_beat;

  assign last_beat = (counter == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; sc_en already has abort folded in, so it is the
  // accepted-beat qualifier for both load and readback.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && (mode == 2'b00)) state_nxt = S_LOAD;
        else if (start && (mode == 2'b01)) state_nxt = S_READ;
      end
      S_LOAD, S_READ: begin
        if (abort) state_nxt = S_IDLE;
        else if (sc_en && last_beat) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; everything is gated by state so reset forces it to 0.
  always_comb begin
    strm.din_ready  = 1'b0;
    strm.dout_valid = 1'b0;
    strm.dout       = '0;
    sc_en           = 1'b0;
    sc_out          = '0;
    done            = 1'b0;
    busy            = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        strm.din_ready = 1'b1;
        sc_out         = strm.din;
        sc_en          = strm.din_valid & ~abort;
      end
      S_READ: begin
        strm.dout_valid = 1'b1;
        strm.dout       = sc_in;
        // Recirculate the tail into the head so a full pass restores the chain.
        sc_out          = sc_in;
        sc_en           = strm.dout_ready & ~abort;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Beat counter, parity accumulator and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      parity  <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode[1]) begin
              err <= 1'b1;
            end else begin
              counter <= '0;
              parity  <= '0;
              err     <= 1'b0;
            end
          end
        end
        S_LOAD, S_READ: begin
          if (abort) begin
            err <= 1'b1;
          end else if (sc_en) begin
            parity  <= parity ^ sc_out;
            counter <= last_beat ? '0 : counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotfpga_scan_loader.sv
module tb_rotfpga_scan_loader;
  localparam int unsigned CL = 8;
  localparam int unsigned CH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic          abort;
  logic          sc_en;
  logic [CH-1:0] sc_out;
  logic [CH-1:0] sc_in;
  logic [CH-1:0] parity;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_err    = 0;

  rotfpga_scan_loader_if #(.CHAINS(CH)) bus ();

  rotfpga_scan_loader #(.CHAIN_LEN(CL), .CHAINS(CH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .abort  (abort),
    .strm   (bus),
    .sc_en  (sc_en),
    .sc_out (sc_out),
    .sc_in  (sc_in),
    .parity (parity),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Behavioural grid: each chain is a shift register, head fed by sc_out,
  // tail presented on sc_in.
  logic [CL-1:0] grid [CH];
  always @(posedge clk) begin
    if (sc_en === 1'b1) begin
      for (int i = 0; i < CH; i++) grid[i] <= {grid[i][CL-2:0], sc_out[i]};
    end
  end
  always_comb begin
    for (int i = 0; i < CH; i++) sc_in[i] = grid[i][CL-1];
  end

  // Reference model: the bit sequence that should sit in each chain, in load order.
  logic [CH-1:0] ld        [CL];
  logic [CH-1:0] exp_chain [CL];

  function automatic logic [CH-1:0] xor_all(input logic [CH-1:0] a [CL]);
    logic [CH-1:0] r = '0;
    for (int k = 0; k < CL; k++) r ^= a[k];
    return r;
  endfunction

  function automatic logic [CL-1:0] chain_image(input logic [CH-1:0] a [CL], input int ch);
    logic [CL-1:0] r = '0;
    for (int k = 0; k < CL; k++) r[CL-1-k] = a[k][ch];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ld();
    for (int k = 0; k < CL; k++) ld[k] = CH'($urandom_range(0, 3));
  endtask

  // vmode: 0 valid held high, 1 valid toggles (low first), 2 random valid
  //        with random stray start pulses.
  // cut_kind: 0 none, 1 abort at beat cut_at, 2 reset at beat cut_at.
  task automatic do_load(input int vmode, input int cut_at, input int cut_kind);
    int k = 0;
    int cyc = 0;
    int pulses = 0;
    logic [CL-1:0] s0, s1;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; bus.din_valid = 1'b0;
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    while (k < CL && cyc < 64) begin
      bus.din = ld[k];
      case (vmode)
        0:       bus.din_valid = 1'b1;
        1:       bus.din_valid = cyc[0];
        default: bus.din_valid = 1'($urandom_range(0, 1));
      endcase
      if (vmode == 2) start = 1'($urandom_range(0, 1));
      if (cut_kind != 0 && k == cut_at) begin
        bus.din_valid = 1'b1;
        if (cut_kind == 1) abort = 1'b1;
        else rst_n = 1'b0;
      end
      #1;
      if (cut_kind == 2 && k == cut_at) begin
        chk("rst_sc_en", sc_en, 0);
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_parity", parity, 0);
        chk("rst_err", err, 0);
        chk("rst_sc_out", sc_out, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        @(negedge clk);
        rst_n = 1'b1; bus.din_valid = 1'b0; start = 1'b0;
        #1 chk("rst_idle_after", busy, 0);
        return;
      end
      if (k == 0 && cyc == 0) chk("start_clears_err", err, 0);
      chk("load_busy", busy, 1);
      chk("load_din_ready", bus.din_ready, 1);
      chk("load_sc_en", sc_en, bus.din_valid & ~abort);
      chk("load_sc_out", sc_out, bus.din);
      chk("load_done", done, 0);
      if (sc_en === 1'b1) pulses++;
      if (cut_kind == 1 && k == cut_at) begin
        s0 = grid[0]; s1 = grid[1];
        @(negedge clk);
        abort = 1'b0; bus.din_valid = 1'b0; start = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 1);
        chk("abort_done", done, 0);
        chk("abort_noshift0", grid[0], s0);
        chk("abort_noshift1", grid[1], s1);
        return;
      end
      @(posedge clk);
      if (bus.din_valid) k++;
      cyc++;
      @(negedge clk);
    end
    chk("load_beats", k, CL);
    chk("load_pulses", pulses, CL);
    if (vmode == 0) chk("load_cycles_solid", cyc, CL);
    if (vmode == 1) chk("load_cycles_toggle", cyc, 2 * CL);
    bus.din_valid = 1'b0; start = 1'b0;
    #1;
    chk("load_fin_done", done, 1);
    chk("load_fin_busy", busy, 1);
    chk("load_fin_sc_en", sc_en, 0);
    exp_chain = ld;
    @(negedge clk);
    #1;
    chk("load_end_done", done, 0);
    chk("load_end_busy", busy, 0);
    chk("load_parity", parity, xor_all(exp_chain));
    chk("load_err", err, 0);
    chk("load_grid0", grid[0], chain_image(exp_chain, 0));
    chk("load_grid1", grid[1], chain_image(exp_chain, 1));
  endtask

  task automatic do_read(input int stall);
    int k = 0;
    int cyc = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; bus.dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (k < CL && cyc < 64) begin
      bus.dout_ready = (cyc < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      chk("read_dout_valid", bus.dout_valid, 1);
      chk("read_din_ready", bus.din_ready, 0);
      chk("read_sc_en", sc_en, bus.dout_ready);
      chk("read_dout", bus.dout, exp_chain[k]);
      @(posedge clk);
      if (bus.dout_ready) k++;
      cyc++;
      @(negedge clk);
    end
    chk("read_beats", k, CL);
    bus.dout_ready = 1'b0;
    #1;
    chk("read_fin_done", done, 1);
    chk("read_fin_dout_valid", bus.dout_valid, 0);
    chk("read_fin_sc_en", sc_en, 0);
    @(negedge clk);
    #1;
    chk("read_end_busy", busy, 0);
    chk("read_parity", parity, xor_all(exp_chain));
    chk("read_grid0", grid[0], chain_image(exp_chain, 0));
    chk("read_grid1", grid[1], chain_image(exp_chain, 1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; abort = 1'b0;
    bus.din = 2'b11; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_parity", parity, 0);
    chk("reset_sc_en", sc_en, 0);
    chk("reset_sc_out", sc_out, 0);
    chk("reset_din_ready", bus.din_ready, 0);
    chk("reset_dout_valid", bus.dout_valid, 0);
    chk("reset_dout", bus.dout, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;

    // Directed load pattern, solid then toggling valid.
    ld = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    do_load(0, -1, 0);
    chk("directed_parity", parity, 2'b01);
    do_load(1, -1, 0);

    // Readback with initial stall, then a second identical pass.
    do_read(3);
    do_read(0);

    // Abort after three accepted beats; next load clears err.
    rand_ld();
    do_load(0, 3, 1);
    rand_ld();
    do_load(2, -1, 0);
    do_read(1);

    // Reserved modes raise err without leaving IDLE; parity is held.
    for (int m = 2; m < 4; m++) begin
      @(negedge clk);
      start = 1'b1; mode = 2'(m);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("badmode_busy", busy, 0);
      chk("badmode_err", err, 1);
      chk("badmode_parity_hold", parity, xor_all(exp_chain));
    end

    // Reset during beat 5, then a full load/readback.
    rand_ld();
    do_load(0, 5, 2);
    rand_ld();
    do_load(0, -1, 0);
    do_read(2);

    // Random traffic.
    for (int r = 0; r < 4; r++) begin
      rand_ld();
      do_load(2, -1, 0);
      do_read(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/rotfpga_scan_loader.md
Name: rotfpga_scan_loader

Overview:
Parametrised configuration controller for the rotatable-tile FPGA grid. It drives CHAINS parallel scan chains of CHAIN_LEN bits each. Supported operations:
- streamed load with ready/valid backpressure;
- non-destructive recirculating readback;
- per-chain parity check;
- abort.

It replaces hand-driven scan-enable/scan-in pins and sits between the chip-level IO mux and the grid's scan ports.

Parameters:
CHAIN_LEN, 64, bits per scan chain (>=2)
CHAINS, 2, number of parallel scan chains (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation selected by mode (sampled in IDLE only)
mode  in  2  00 load, 01 readback, 10/11 reserved
abort  in  1  terminate current operation
din  in  CHAINS  load data, bit i -> chain i
din_valid  in  1  din valid
din_ready  out  1  controller accepts din this cycle
dout  out  CHAINS  readback data, bit i from chain i
dout_valid  out  1  dout valid
dout_ready  in  1  consumer accepts dout
sc_en  out  1  grid scan enable (grid shifts on clk edge when high)
sc_out  out  CHAINS  grid scan inputs
sc_in  in  CHAINS  grid scan outputs (last tile of each chain)
parity  out  CHAINS  XOR of all bits shifted into chain i during the last load/readback
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n low):
  - FSM=IDLE, counter=0, parity=0, err=0, done=0.
  - Combinational outputs resolve to 0: din_ready, dout_valid, sc_en, sc_out, dout, busy.
- FSM states: IDLE, LOAD, READ, FIN.
- IDLE:
  - start & mode=00 -> LOAD; start & mode=01 -> READ. On either: counter=0, parity=0, err=0.
  - start & mode in {10,11} -> stay IDLE, err=1.
  - start outside IDLE is ignored.
- LOAD:
  - din_ready=1.
  - sc_en = din_valid (combinational); sc_out = din (combinational).
  - On handshake: counter++, parity ^= din.
  - Handshake with counter==CHAIN_LEN-1 -> FIN.
  - No handshake -> sc_en=0; counter and grid hold.
- READ:
  - dout_valid=1, dout = sc_in (combinational).
  - sc_out = sc_in (recirculate); sc_en = dout_ready.
  - On handshake: counter++, parity ^= sc_in.
  - Handshake with counter==CHAIN_LEN-1 -> FIN.
  - After exactly CHAIN_LEN shifts the chain contents equal their pre-readback values.
  - First dout equals the last-loaded bit position's tail (i.e. the first bit loaded appears first).
- FIN: done=1 for exactly one cycle, sc_en=0, busy=1; next state IDLE.
- Abort:
  - abort high in LOAD or READ -> IDLE next cycle, err=1, no done pulse.
  - abort has priority over a same-cycle handshake: sc_en forced 0, counter not advanced.
  - Grid contents are then partial and undefined; a new load is required.
  - abort in IDLE/FIN has no effect.
- busy = (state != IDLE).
- counter width = clog2(CHAIN_LEN); it never exceeds CHAIN_LEN-1.
- parity is registered and holds its value through IDLE until the next accepted start.
- err clears only on an accepted start with a valid mode, or on reset.
- Reset mid-operation: immediate return to reset values; grid scan stops (sc_en=0) asynchronously.

Test Plan:
- CHAIN_LEN=8, CHAINS=2:
  - load din = 01,10,11,00,01,01,10,11 with din_valid held high;
  - expect sc_en high 8 cycles, done pulse on 9th cycle, busy low after;
  - expect parity = 2'b11 ^ 2'b10 ^ ... computed = 2'b01^2'b10^2'b11^2'b00^2'b01^2'b01^2'b10^2'b11 = 2'b01, err=0.
- Load as above with din_valid toggling every other cycle -> exactly 8 sc_en pulses over 16 cycles, done after 8th accepted beat, grid model matches.
- After load, readback with dout_ready low for 3 cycles then high:
  - expect no shift while low;
  - dout sequence = 01,10,11,00,01,01,10,11;
  - parity = 2'b01;
  - a second readback returns an identical sequence (non-destructive).
- Abort after 3 accepted load beats, asserted together with din_valid -> no shift that cycle, IDLE next cycle, err=1, no done; next valid start clears err.
- start with mode=2'b11 in IDLE -> busy stays 0, err=1; start with mode=00 while busy in LOAD -> ignored, counter unaffected.
- rst_n low at beat 5 of load -> all outputs 0 immediately, FSM IDLE; after release, a full load completes normally.
